pe_comm_ctrl: RTL and testbench
===============================

# pe_comm_ctrl

PE-side communication controller that drives the send/receive handshake of the node's router interface (`m_if_2_router_v3`) from inside `node_module`, replacing the static request/valid registers. On the transmit side it buffers PE result words, raises a send request with header fields, and streams exactly `seq_len` words after the ack. On the receive side it acks incoming-packet requests and unpacks 64-bit payload words into the PE's A/B operands.

## Interface
- `LOCAL_ID`, 8'd0, driven on `o_src` for every packet
- `FIFO_DEPTH`, 8, transmit buffer depth in 32-bit words (power of two, ≥2)
- `clk`  in  1  node clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `i_pe_data`  in  32  PE result word (add/mult already selected)
- `i_pe_valid`  in  1  push `i_pe_data` into TX FIFO
- `i_tx_start`  in  1  launch a packet; sampled only in TX_IDLE
- `i_tx_dst` / `i_tx_seq_len` / `i_tx_id`  in  8 / 6 / 6  header, latched with `i_tx_start`
- `o_tx_busy`  out  1  TX FSM not in TX_IDLE
- `o_tx_done`  out  1  one-cycle pulse at packet end
- `o_overflow`  out  1  sticky: push while FIFO full
- `o_fifo_count`  out  4  TX FIFO occupancy
- `o_comm_send_req`  out  1  to IF `i_comm_send_req`
- `i_comm_send_ack`  in  1  from IF `o_comm_send_ack`
- `o_data` / `o_data_valid`  out  32 / 1  to IF `i_data` / `i_data_valid`
- `o_src` / `o_dst` / `o_seq_len` / `o_id`  out  8 / 8 / 6 / 6  header to IF
- `i_req_rx`  in  1  from IF `o_req_rx`
- `o_ack_rx`  out  1  to IF `i_ack_rx`
- `i_data_input` / `i_data_input_valid`  in  64 / 1  from IF
- `o_op_a` / `o_op_b`  out  32  PE operands
- `o_op_valid`  out  1  one-cycle pulse, operands updated

## Operation
- Reset: all outputs 0 except `o_src`=LOCAL_ID; FIFO emptied; both FSMs idle; `o_overflow` cleared. Asserting reset mid-packet drops `o_comm_send_req`/`o_data_valid` immediately; the partial packet is abandoned.
- FIFO: push on `i_pe_valid` when not full; push when full drops the word and sets `o_overflow`. Push and pop in the same cycle are both honoured (count unchanged, even when full). Pointers wrap modulo FIFO_DEPTH. `o_data` = FIFO head (first-word fall-through).
- TX FSM: TX_IDLE → TX_WAIT on `i_tx_start` (latch header; `seq_len`=0 ignored, stays idle; `seq_len`>FIFO_DEPTH clamped to FIFO_DEPTH, clamped value on `o_seq_len`). TX_WAIT → TX_REQ when count ≥ seq_len. TX_REQ: `o_comm_send_req`=1 until `i_comm_send_ack` sampled 1, then TX_STREAM. TX_STREAM: `o_data_valid`=1 and one pop per cycle for exactly seq_len cycles, then TX_DONE (`o_tx_done`=1) → TX_IDLE. Header outputs held stable from TX_REQ through TX_STREAM. Ack outside TX_REQ ignored; `i_tx_start` while busy ignored.
- RX FSM: RX_IDLE → RX_ACK when `i_req_rx`=1; RX_ACK drives `o_ack_rx`=1 for one cycle → RX_HOLD; RX_HOLD → RX_IDLE when `i_req_rx`=0.
- Payload: every `i_data_input_valid` cycle (any RX state) registers `o_op_a`=`i_data_input[63:32]`, `o_op_b`=`i_data_input[31:0]`, pulses `o_op_valid` next cycle. Operands hold between pulses.

## Timing
- Start at cycle T with FIFO already holding ≥seq_len: TX_WAIT at T+1, `o_comm_send_req` high from T+2.
- Ack sampled at cycle A: `o_data_valid` high A+1 … A+seq_len; `o_tx_done` at A+seq_len+1; `o_tx_busy` low from A+seq_len+2.
- `i_req_rx` rises at R: `o_ack_rx` high only at R+1.
- `i_data_input_valid` at D: `o_op_valid` and new operands at D+1; back-to-back valids give back-to-back pulses.

## Structure
- Shared package/include `pe_comm_pkg`: TX/RX state encodings, `DATA_W`=32, `ADDR_W`=8, `SEQ_W`=6, `ID_W`=6, `PAYLOAD_W`=64.
- One sub-module: `pe_comm_fifo` (parameterised sync FIFO, FWFT, count/full/empty outputs).

## Test plan
- Push 4 words 0x40200000,0x40800000,0x3F900000,0x1; start dst=8'h05 seq_len=4 id=3; ack 3 cycles after req → req held 3 cycles, 4 consecutive valids with those words in order, `o_tx_done` one cycle later, count=0.
- Start seq_len=3 with empty FIFO; push one word every 2 cycles → req rises only on cycle after third push.
- Fill FIFO (8), push a 9th → `o_overflow`=1, count stays 8; simultaneous push+pop while full → count 8, no overflow change.
- seq_len=0 → no req, busy stays 0; seq_len=12 → `o_seq_len`=8, 8 valids.
- `i_req_rx` held 5 cycles, then `i_data_input`=64'h40400000_40800000 valid → single `o_ack_rx` pulse; `o_op_a`=0x40400000, `o_op_b`=0x40800000, one `o_op_valid`.
- Assert `rst_n`=0 during TX_STREAM word 2 → req/valid/count 0 immediately; after release a fresh 2-word packet completes normally.

Source files
------------

// File: rtl/pe_comm_pkg.sv
// Shared widths, FSM encodings and the seq_len clamp helper for the PE
// communication controller.
package pe_comm_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 8;
  localparam int SEQ_W     = 6;
  localparam int ID_W      = 6;
  localparam int PAYLOAD_W = 64;

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_WAIT   = 3'd1;
  localparam logic [2:0] TX_REQ    = 3'd2;
  localparam logic [2:0] TX_STREAM = 3'd3;
  localparam logic [2:0] TX_DONE   = 3'd4;

  localparam logic [1:0] RX_IDLE = 2'd0;
  localparam logic [1:0] RX_ACK  = 2'd1;
  localparam logic [1:0] RX_HOLD = 2'd2;

  // A packet can never be longer than what the transmit buffer can hold.
  function automatic logic [SEQ_W-1:0] clamp_seq(input logic [SEQ_W-1:0] len,
                                                 input int depth);
    if (int'(len) > depth) return SEQ_W'(depth);
    return len;
  endfunction

endpackage

// File: rtl/pe_comm_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is only
// accepted when a pop frees a slot in the same cycle.
module pe_comm_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_data  = mem_q[rd_ptr_q];
  assign o_count = count_q;

  always_comb begin
    pop_ok   = i_pop && !o_empty;
    push_ok  = i_push && (!o_full || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pe_comm_ctrl.sv
// PE-side controller for the router interface: buffers PE results into
// packets on the transmit side and unpacks received payloads into operands.
module pe_comm_ctrl
  import pe_comm_pkg::*;
#(
  parameter logic [7:0] LOCAL_ID   = 8'd0,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   i_pe_data,
  input  logic                          i_pe_valid,
  input  logic                          i_tx_start,
  input  logic [7:0]                    i_tx_dst,
  input  logic [5:0]                    i_tx_seq_len,
  input  logic [5:0]                    i_tx_id,
  output logic                          o_tx_busy,
  output logic                          o_tx_done,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_comm_send_req,
  input  logic                          i_comm_send_ack,
  output logic [31:0]                   o_data,
  output logic                          o_data_valid,
  output logic [7:0]                    o_src,
  output logic [7:0]                    o_dst,
  output logic [5:0]                    o_seq_len,
  output logic [5:0]                    o_id,
  input  logic                          i_req_rx,
  output logic                          o_ack_rx,
  input  logic [63:0]                   i_data_input,
  input  logic                          i_data_input_valid,
  output logic [31:0]                   o_op_a,
  output logic [31:0]                   o_op_b,
  output logic                          o_op_valid,
  output logic [2:0]                    o_tx_state,
  output logic [1:0]                    o_rx_state
);
  // Handshakes: send_req stays high until send_ack is sampled high, then
  // data_valid is high for exactly seq_len cycles with one word per cycle;
  // ack_rx is a single-cycle answer to a rising req_rx, re-armed once req_rx drops.
  logic [2:0]        tx_state_q, tx_state_d;
  logic [1:0]        rx_state_q, rx_state_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [SEQ_W-1:0]  left_q, left_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic              op_valid_q, op_valid_d;
  logic              tx_pop, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign tx_pop = (tx_state_q == TX_STREAM) && !fifo_empty;

  pe_comm_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (i_pe_valid),
    .i_data  (i_pe_data),
    .i_pop   (tx_pop),
    .o_data  (o_data),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    dst_d      = dst_q;
    seq_d      = seq_q;
    id_d       = id_q;
    left_d     = left_q;
    case (tx_state_q)
      TX_IDLE: if (i_tx_start && i_tx_seq_len != '0) begin
        dst_d      = i_tx_dst;
        seq_d      = clamp_seq(i_tx_seq_len, FIFO_DEPTH);
        id_d       = i_tx_id;
        tx_state_d = TX_WAIT;
      end
      TX_WAIT: if (SEQ_W'(fifo_count) >= seq_q) tx_state_d = TX_REQ;
      TX_REQ: if (i_comm_send_ack) begin
        left_d     = seq_q;
        tx_state_d = TX_STREAM;
      end
      TX_STREAM: begin
        left_d = left_q - SEQ_W'(1);
        if (left_q == SEQ_W'(1)) tx_state_d = TX_DONE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE: if (i_req_rx) rx_state_d = RX_ACK;
      RX_ACK:  rx_state_d = RX_HOLD;
      RX_HOLD: if (!i_req_rx) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A dropped word is only an overflow if no pop made room for it.
  always_comb begin
    overflow_d = overflow_q | (i_pe_valid & fifo_full & ~tx_pop);
    op_valid_d = i_data_input_valid;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    if (i_data_input_valid) begin
      op_a_d = i_data_input[PAYLOAD_W-1:DATA_W];
      op_b_d = i_data_input[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      dst_q      <= '0;
      seq_q      <= '0;
      id_q       <= '0;
      left_q     <= '0;
      overflow_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      dst_q      <= dst_d;
      seq_q      <= seq_d;
      id_q       <= id_d;
      left_q     <= left_d;
      overflow_q <= overflow_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign o_tx_busy       = (tx_state_q != TX_IDLE);
  assign o_tx_done       = (tx_state_q == TX_DONE);
  assign o_comm_send_req = (tx_state_q == TX_REQ);
  assign o_data_valid    = (tx_state_q == TX_STREAM);
  assign o_ack_rx        = (rx_state_q == RX_ACK);
  assign o_overflow      = overflow_q;
  assign o_fifo_count    = fifo_count;
  assign o_src           = LOCAL_ID;
  assign o_dst           = dst_q;
  assign o_seq_len       = seq_q;
  assign o_id            = id_q;
  assign o_op_a          = op_a_q;
  assign o_op_b          = op_b_q;
  assign o_op_valid      = op_valid_q;
  assign o_tx_state      = tx_state_q;
  assign o_rx_state      = rx_state_q;

endmodule

// File: tb/tb_pe_comm_ctrl.sv
// Directed bench for pe_comm_ctrl: expected words/operands are queued when
// stimulus is issued and a negedge monitor pops and compares them.
module tb_pe_comm_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_pe_data;
  logic        i_pe_valid;
  logic        i_tx_start;
  logic [7:0]  i_tx_dst;
  logic [5:0]  i_tx_seq_len;
  logic [5:0]  i_tx_id;
  logic        o_tx_busy, o_tx_done, o_overflow;
  logic [3:0]  o_fifo_count;
  logic        o_comm_send_req, i_comm_send_ack;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic [7:0]  o_src, o_dst;
  logic [5:0]  o_seq_len, o_id;
  logic        i_req_rx, o_ack_rx;
  logic [63:0] i_data_input;
  logic        i_data_input_valid;
  logic [31:0] o_op_a, o_op_b;
  logic        o_op_valid;
  logic [2:0]  o_tx_state;
  logic [1:0]  o_rx_state;

  logic [31:0] exp_q[$];
  logic [63:0] exp_op_q[$];
  int errors   = 0;
  int n_checks = 0;
  int n_valid  = 0;
  int n_ack    = 0;
  int n_op     = 0;

  pe_comm_ctrl #(.LOCAL_ID(8'd0), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_pe_data(i_pe_data), .i_pe_valid(i_pe_valid),
    .i_tx_start(i_tx_start), .i_tx_dst(i_tx_dst),
    .i_tx_seq_len(i_tx_seq_len), .i_tx_id(i_tx_id),
    .o_tx_busy(o_tx_busy), .o_tx_done(o_tx_done),
    .o_overflow(o_overflow), .o_fifo_count(o_fifo_count),
    .o_comm_send_req(o_comm_send_req), .i_comm_send_ack(i_comm_send_ack),
    .o_data(o_data), .o_data_valid(o_data_valid),
    .o_src(o_src), .o_dst(o_dst), .o_seq_len(o_seq_len), .o_id(o_id),
    .i_req_rx(i_req_rx), .o_ack_rx(o_ack_rx),
    .i_data_input(i_data_input), .i_data_input_valid(i_data_input_valid),
    .o_op_a(o_op_a), .o_op_b(o_op_b), .o_op_valid(o_op_valid),
    .o_tx_state(o_tx_state), .o_rx_state(o_rx_state)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_data_valid) begin
        n_valid++;
        if (exp_q.size() == 0) check("tx_unexpected_word", {32'd0, o_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("tx_word", {32'd0, o_data}, {32'd0, exp_q.pop_front()});
      end
      if (o_op_valid) begin
        n_op++;
        if (exp_op_q.size() == 0) check("op_unexpected", {o_op_a, o_op_b}, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("op_pair", {o_op_a, o_op_b}, exp_op_q.pop_front());
      end
      if (o_ack_rx) n_ack++;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input bit expected_out);
    i_pe_valid = 1'b1;
    i_pe_data  = w;
    if (expected_out) exp_q.push_back(w);
    tick();
    i_pe_valid = 1'b0;
  endtask

  task automatic start_pkt(input logic [7:0] dst, input logic [5:0] len, input logic [5:0] id);
    i_tx_start   = 1'b1;
    i_tx_dst     = dst;
    i_tx_seq_len = len;
    i_tx_id      = id;
    tick();
    i_tx_start   = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int waited = 0;
    while (!o_comm_send_req && waited < 50) begin
      tick();
      waited++;
    end
    check(name, o_comm_send_req, 1);
  endtask

  // Called in a stream cycle; expects done after `remaining` more cycles.
  task automatic wait_done(input string name, input int remaining);
    int waited = 0;
    while (!o_tx_done && waited < 40) begin
      tick();
      waited++;
    end
    check({name, "_done_latency"}, waited, remaining);
    tick();
    check({name, "_busy_after"}, o_tx_busy, 0);
  endtask

  task automatic ack_and_finish(input string name, input int len);
    int v0;
    i_comm_send_ack = 1'b1;
    tick();
    i_comm_send_ack = 1'b0;
    v0 = n_valid;
    check({name, "_req_dropped"}, o_comm_send_req, 0);
    wait_done(name, len);
    check({name, "_valid_count"}, n_valid - v0, len);
  endtask

  initial begin
    rst_n = 1'b1;
    i_pe_data = '0; i_pe_valid = 1'b0; i_tx_start = 1'b0;
    i_tx_dst = '0; i_tx_seq_len = '0; i_tx_id = '0;
    i_comm_send_ack = 1'b0; i_req_rx = 1'b0;
    i_data_input = '0; i_data_input_valid = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    check("rst_busy", o_tx_busy, 0);
    check("rst_req", o_comm_send_req, 0);
    check("rst_valid", o_data_valid, 0);
    check("rst_count", o_fifo_count, 0);
    check("rst_ack_rx", o_ack_rx, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_src", o_src, 8'd0);
    check("rst_ops", {o_op_a, o_op_b, 1'b0, o_op_valid}, 0);
    rst_n = 1'b1;
    tick();

    // basic packet, ack three cycles after req
    push_word(32'h4020_0000, 1);
    push_word(32'h4080_0000, 1);
    push_word(32'h3F90_0000, 1);
    push_word(32'h0000_0001, 1);
    check("t1_count4", o_fifo_count, 4);
    start_pkt(8'h05, 6'd4, 6'd3);
    check("t1_wait_state", o_tx_state, 3'd1);
    check("t1_no_req_in_wait", o_comm_send_req, 0);
    tick();
    check("t1_req_cycle1", o_comm_send_req, 1);
    check("t1_hdr", {o_src, o_dst, 2'b0, o_seq_len, 2'b0, o_id}, {8'h00, 8'h05, 8'd4, 8'd3});
    tick();
    check("t1_req_cycle2", o_comm_send_req, 1);
    tick();
    check("t1_req_cycle3", o_comm_send_req, 1);
    ack_and_finish("t1", 4);
    check("t1_count0", o_fifo_count, 0);

    // start with empty FIFO, push every other cycle
    start_pkt(8'h11, 6'd3, 6'd7);
    for (int i = 0; i < 3; i++) begin
      push_word(32'hA000_0000 + i, 1);
      check("t2_req_low_after_push", o_comm_send_req, 0);
      tick();
      check("t2_req_after_gap", o_comm_send_req, (i == 2));
    end
    ack_and_finish("t2", 3);

    // overflow and push+pop while full
    for (int i = 0; i < 8; i++) push_word(32'h100 + i, 1);
    check("t3_full_count", o_fifo_count, 8);
    check("t3_no_overflow_yet", o_overflow, 0);
    push_word(32'hDEAD_BEEF, 0);
    check("t3_overflow_set", o_overflow, 1);
    check("t3_count_stays_8", o_fifo_count, 8);
    start_pkt(8'h07, 6'd8, 6'd1);
    wait_req("t3_req");
    i_comm_send_ack = 1'b1;
    tick();
    i_comm_send_ack = 1'b0;
    push_word(32'h200, 1);
    check("t3_pushpop_count", o_fifo_count, 8);
    check("t3_overflow_sticky", o_overflow, 1);
    wait_done("t3", 7);
    check("t3_leftover", o_fifo_count, 1);

    // seq_len zero and clamp
    start_pkt(8'h09, 6'd0, 6'd2);
    check("t4_zero_busy", o_tx_busy, 0);
    tick();
    check("t4_zero_req", {o_tx_busy, o_comm_send_req}, 0);
    for (int i = 0; i < 7; i++) push_word(32'h300 + i, 1);
    start_pkt(8'h0A, 6'd12, 6'd5);
    check("t4_clamped_len", o_seq_len, 6'd8);
    wait_req("t4_req");
    ack_and_finish("t4", 8);
    check("t4_count0", o_fifo_count, 0);

    // receive side
    n_ack = 0;
    i_req_rx = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t5_ack_rx_cycle", o_ack_rx, (k == 0));
    end
    i_req_rx = 1'b0;
    tick();
    tick();
    check("t5_single_ack", n_ack, 1);
    check("t5_rx_idle", o_rx_state, 2'd0);
    n_op = 0;
    i_data_input = 64'h4040_0000_4080_0000;
    i_data_input_valid = 1'b1;
    exp_op_q.push_back(64'h4040_0000_4080_0000);
    tick();
    i_data_input_valid = 1'b0;
    check("t5_op_a", o_op_a, 32'h4040_0000);
    check("t5_op_b", o_op_b, 32'h4080_0000);
    check("t5_op_valid", o_op_valid, 1);
    tick();
    check("t5_op_valid_low", o_op_valid, 0);
    check("t5_op_a_hold", o_op_a, 32'h4040_0000);
    i_data_input_valid = 1'b1;
    i_data_input = 64'h1111_2222_3333_4444;
    exp_op_q.push_back(64'h1111_2222_3333_4444);
    tick();
    i_data_input = 64'hAAAA_BBBB_CCCC_DDDD;
    exp_op_q.push_back(64'hAAAA_BBBB_CCCC_DDDD);
    tick();
    i_data_input_valid = 1'b0;
    check("t5_b2b_pulse2", o_op_valid, 1);
    tick();
    check("t5_op_count", n_op, 3);

    // reset during the second streamed word
    for (int i = 0; i < 4; i++) push_word(32'h500 + i, 1);
    start_pkt(8'h0C, 6'd4, 6'd9);
    wait_req("t6_req");
    i_comm_send_ack = 1'b1;
    tick();
    i_comm_send_ack = 1'b0;
    tick();
    check("t6_streaming", o_data_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", o_comm_send_req, 0);
    check("t6_rst_valid", o_data_valid, 0);
    check("t6_rst_count", o_fifo_count, 0);
    check("t6_rst_busy", o_tx_busy, 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    push_word(32'h600, 1);
    push_word(32'h601, 1);
    start_pkt(8'h0D, 6'd2, 6'd4);
    wait_req("t6_fresh_req");
    ack_and_finish("t6_fresh", 2);

    check("end_tx_queue_empty", exp_q.size(), 0);
    check("end_op_queue_empty", exp_op_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
